mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC data memory bus using the valid/ready request protocol.
- Lets a second requester (DMA engine or debug loader, master 1) share the memory/peripheral decode fabric with the CPU data port (master 0).
- Sits between the requesters and the address decoder that fans out to ROM, FRAM, RAM and GPIO.
- Round-robin grant; a grant is held until the slave completes the transfer.

Parameters:
- PRIORITY_M0, 0, 1 = fixed priority to master 0 on contention; 0 = round-robin.
- TIMEOUT_CYCLES, 255, cycles in a grant state without s_ready before the transfer is aborted. Used only with ARB_TIMEOUT_EN; range 1..65535.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- m0_valid  input  1  master 0 request; held with fields stable until m0_ready
- m0_addr  input  32  master 0 byte address
- m0_wdata  input  32  master 0 write data
- m0_wstrb  input  4  master 0 byte strobes; 0 = read
- m0_rdata  output  32  master 0 read data, valid when m0_ready=1
- m0_ready  output  1  master 0 completion pulse
- m0_err  output  1  master 0 abort pulse (timeout)
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready, m1_err: same as master 0, for master 1
- s_valid  output  1  request to decoder
- s_addr  output  32  forwarded address
- s_wdata  output  32  forwarded write data
- s_wstrb  output  4  forwarded strobes
- s_rdata  input  32  slave read data
- s_ready  input  1  slave completion
- grant  output  2  one-hot current owner; 00 when idle
- busy  output  1  high in any grant state

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- States: IDLE, GNT0, GNT1, and DONE (one cycle). Registers: state, last (last master served), and timeout counter tcnt[15:0].
- Reset values: state=IDLE, last=1 (so master 0 wins first contention), tcnt=0. All outputs 0, including s_valid, s_addr, s_wdata, s_wstrb, mN_ready, mN_rdata, mN_err and grant; busy=0.
- Arbitration in IDLE, registered decision:
  - Only m0_valid -> GNT0.
  - Only m1_valid -> GNT1.
  - Both, with PRIORITY_M0=1 -> GNT0.
  - Both, with PRIORITY_M0=0 -> the master not equal to last.
  - Neither -> stay in IDLE.
- Arbitration costs exactly 1 cycle. Request at cycle N gives s_valid at N+1.
- In GNTk:
  - s_valid = mk_valid. s_addr, s_wdata and s_wstrb are driven combinationally from master k.
  - grant is one-hot k. busy=1.
  - Non-granted master: ready=0, rdata=0.
- Completion: s_ready=1 in GNTk produces a combinational same-cycle response.
  - mk_ready=1 and mk_rdata=s_rdata.
  - Next state is DONE, and last is updated to k.
- DONE: s_valid=0 and no ready. Next cycle returns to IDLE. This guarantees one idle bus cycle, so a master that drops valid one cycle late is not re-granted by mistake.
- Back-to-back: a master requesting continuously while the other is idle gets one transfer per 3 cycles minimum (arb, grant+ready, done).
- Abort: if mk_valid drops in GNTk before s_ready (protocol violation), the arbiter goes to IDLE next cycle. No ready is issued and last is unchanged.
- Spurious s_ready in IDLE or DONE is ignored.
- Reset asserted mid-transfer forces IDLE immediately (asynchronous). s_valid drops without a cycle boundary.
- Fields are passed through, not latched. Masters must hold their fields stable while valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - tcnt clears on entry to GNTk and increments each GNTk cycle without s_ready.
  - When tcnt == TIMEOUT_CYCLES-1 and s_ready=0, that cycle issues mk_ready=1, mk_err=1 and mk_rdata=32'hDEAD_BEEF. s_valid is forced to 0 that cycle. Next state is DONE and last=k.
  - s_ready on the timeout cycle takes precedence: normal completion, err=0.
- Without the macro: no counter logic; m0_err and m1_err are tied to 0; a stuck slave holds the grant forever.

Test Plan:
- Reset check: assert reset, then release -> all outputs 0, grant=00, busy=0.
- Single read: m0 read of 0x2000_0010 while slave returns 0x1234_5678 with s_ready two cycles after s_valid -> s_valid 1 cycle after m0_valid; m0_ready pulses 1 cycle carrying 0x1234_5678; grant 01 then 00; one DONE cycle.
- Contention, round-robin (PRIORITY_M0=0): m0 and m1 valid simultaneously and continuously, slave s_ready after 1 cycle -> grants alternate 01, 10, 01, 10; first grant 01.
- Fixed priority (PRIORITY_M0=1): same stimulus -> m0 always granted; m1 granted only after m0_valid drops.
- Write passthrough and abort: m1 writes 0x4000_0000 with wdata=0xA5 and wstrb=0001 -> s_* match m1. In a second transfer m1_valid drops before s_ready -> no m1_ready; IDLE next cycle; last unchanged.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m0 request, s_ready never asserted -> 4th grant cycle gives m0_ready=1, m0_err=1, rdata 0xDEAD_BEEF, s_valid=0. Then DONE, then IDLE. Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-master, one-slave valid/ready arbiter for the SoC data
//               memory bus. Master 0 is the CPU data port and master 1 is a
//               DMA engine or debug loader. Grants are round-robin, or fixed
//               priority to master 0 when PRIORITY_M0=1. A grant is held until
//               the slave completes, and is followed by one DONE bus cycle.
//               Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a
//               grant that waits TIMEOUT_CYCLES cycles for s_ready is aborted
//               with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned PRIORITY_M0    = 0,   // 1: master 0 wins contention
    parameter int unsigned TIMEOUT_CYCLES = 255  // 1..65535, ARB_TIMEOUT_EN only
) (
    input  logic        clk,
    input  logic        reset,

    // Master 0 (CPU data port)
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,

    // Master 1 (DMA / debug loader)
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,

    // Slave side (address decoder)
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    // Status
    output logic [1:0]  grant,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] C_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // An out-of-range timeout has no sensible meaning; the guard keeps the
    // parameter referenced in builds without the timeout feature.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_unsupported
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic        last_q,  last_d;   // last master served: 0 or 1

    // ------------------------------------------------------------------------
    // Datapath selection for the master currently holding the bus
    // ------------------------------------------------------------------------
    logic        w_in_grant;
    logic        w_sel_m1;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_wstrb;
    logic        w_complete;        // slave finished the granted transfer
    logic        w_timeout;         // grant aborted by the watchdog
    logic        w_resp_ready;
    logic [31:0] w_resp_rdata;

    assign w_in_grant = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign w_sel_m1   = (state_q == ST_GNT1);

    // Route the owning master's request fields toward the slave
    always_comb begin
        w_req_valid = 1'b0;
        w_req_addr  = 32'd0;
        w_req_wdata = 32'd0;
        w_req_wstrb = 4'd0;
        if (state_q == ST_GNT0) begin
            w_req_valid = m0_valid;
            w_req_addr  = m0_addr;
            w_req_wdata = m0_wdata;
            w_req_wstrb = m0_wstrb;
        end else if (state_q == ST_GNT1) begin
            w_req_valid = m1_valid;
            w_req_addr  = m1_addr;
            w_req_wdata = m1_wdata;
            w_req_wstrb = m1_wstrb;
        end
    end

    // A completion only counts while the owner still asserts valid; a master
    // that dropped valid is treated as an abort even if s_ready shows up.
    assign w_complete = w_in_grant && w_req_valid && s_ready;

`ifdef ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Grant watchdog
    // ------------------------------------------------------------------------
    localparam logic [15:0] C_TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tcnt_q, tcnt_d;

    // Count grant cycles spent waiting on the slave; zero everywhere else so
    // each new grant starts counting from 0.
    always_comb begin
        tcnt_d = 16'd0;
        if (w_in_grant && w_req_valid && !s_ready) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= 16'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    // s_ready on the final cycle wins, so the timeout requires !s_ready
    assign w_timeout = w_in_grant && w_req_valid && !s_ready
                       && (tcnt_q == C_TCNT_LAST);
`else
    // Without the watchdog a stuck slave holds the grant indefinitely
    assign w_timeout = 1'b0;
`endif

    assign w_resp_ready = w_complete || w_timeout;

    // Read data returned to the owner: slave data, or the error marker
    always_comb begin
        w_resp_rdata = 32'd0;
        if (w_complete) begin
            w_resp_rdata = s_rdata;
        end else if (w_timeout) begin
            w_resp_rdata = C_TIMEOUT_RDATA;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Slave request is passed through unlatched; idle/DONE drive all zeros
    always_comb begin
        s_valid = w_in_grant && w_req_valid && !w_timeout;
        s_addr  = w_req_addr;
        s_wdata = w_req_wdata;
        s_wstrb = w_req_wstrb;
    end

    // Responses go only to the owning master; the other sees zeros
    always_comb begin
        m0_ready = 1'b0;
        m0_rdata = 32'd0;
        m0_err   = 1'b0;
        m1_ready = 1'b0;
        m1_rdata = 32'd0;
        m1_err   = 1'b0;
        if (w_sel_m1) begin
            m1_ready = w_resp_ready;
            m1_rdata = w_resp_rdata;
            m1_err   = w_timeout;
        end else begin
            m0_ready = w_resp_ready;
            m0_rdata = w_resp_rdata;
            m0_err   = w_timeout;
        end
    end

    assign grant = {w_in_grant && w_sel_m1, w_in_grant && !w_sel_m1};
    assign busy  = w_in_grant;

    // ------------------------------------------------------------------------
    // Arbitration and transfer sequencing
    // ------------------------------------------------------------------------

    // Next-state decision: arbitrate in IDLE, hold grant until done or abort
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    // Round-robin picks whichever master was not served last
                    if ((PRIORITY_M0 != 0) || last_q) begin
                        state_d = ST_GNT0;
                    end else begin
                        state_d = ST_GNT1;
                    end
                end else if (m0_valid) begin
                    state_d = ST_GNT0;
                end else if (m1_valid) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (!w_req_valid) begin
                    // Owner withdrew mid-transfer: release without response
                    state_d = ST_IDLE;
                end else if (w_resp_ready) begin
                    state_d = ST_DONE;
                    last_d  = w_sel_m1;
                end
            end
            ST_DONE: begin
                // Guaranteed dead cycle so a late valid drop is not re-granted
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and fairness registers; last resets to 1 so master 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter. Two
//               instances share all stimulus: u_rr (round-robin) and u_fp
//               (fixed priority to master 0), both with TIMEOUT_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
    logic        rr_m0_ready, rr_m0_err, rr_m1_ready, rr_m1_err, rr_s_valid, rr_busy;
    logic [3:0]  rr_s_wstrb;
    logic [1:0]  rr_grant;

    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic        fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err, fp_s_valid, fp_busy;
    logic [3:0]  fp_s_wstrb;
    logic [1:0]  fp_grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.PRIORITY_M0(0), .TIMEOUT_CYCLES(4)) u_rr (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(rr_m0_rdata), .m0_ready(rr_m0_ready), .m0_err(rr_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(rr_m1_rdata), .m1_ready(rr_m1_ready), .m1_err(rr_m1_err),
        .s_valid(rr_s_valid), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(rr_grant), .busy(rr_busy)
    );

    mem_bus_arbiter #(.PRIORITY_M0(1), .TIMEOUT_CYCLES(4)) u_fp (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(fp_m0_rdata), .m0_ready(fp_m0_ready), .m0_err(fp_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(fp_m1_rdata), .m1_ready(fp_m1_ready), .m1_err(fp_m1_err),
        .s_valid(fp_s_valid), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(fp_grant), .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;

        reset = 1'b1;
        m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
        m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
        s_ready = 1'b0; s_rdata = 32'd0;

        // ---------------- Reset ----------------
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_s_valid", rr_s_valid, 1'b0);
        chk("rst_grant",   rr_grant,   2'b00);
        chk("rst_busy",    rr_busy,    1'b0);
        chk("rst_m0_ready", rr_m0_ready, 1'b0);
        chk("rst_m0_rdata", rr_m0_rdata, 32'd0);
        chk("rst_m1_err",  rr_m1_err,  1'b0);
        chk("rst_s_addr",  rr_s_addr,  32'd0);
        chk("rst_s_wstrb", rr_s_wstrb, 4'd0);

        // ---------------- Contention ----------------
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_arb_grant", rr_grant, 2'b00);
            cyc();
            s_ready = 1'b0;
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_grant", rr_grant, exp_g);
            chk("rr_s_addr", rr_s_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            chk("fp_grant", fp_grant, 2'b01);
            cyc();
            s_ready = 1'b1; s_rdata = 32'h1000 + i;
            #1;
            if (exp_g == 2'b01) begin
                chk("rr_m0_ready", rr_m0_ready, 1'b1);
                chk("rr_m1_ready_idle", rr_m1_ready, 1'b0);
            end else begin
                chk("rr_m1_ready", rr_m1_ready, 1'b1);
                chk("rr_m0_rdata_idle", rr_m0_rdata, 32'd0);
            end
            chk("fp_m0_ready", fp_m0_ready, 1'b1);
            cyc();
            s_ready = 1'b0;
            #1;
            chk("cont_done_grant", rr_grant, 2'b00);
            cyc();
        end
        // Fixed priority: m1 only after m0 withdraws
        m0_valid = 1'b0;
        #1;
        cyc();
        chk("fp_grant_m1", fp_grant, 2'b10);
        chk("rr_grant_m1", rr_grant, 2'b10);
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        #1;
        chk("fp_m1_ready", fp_m1_ready, 1'b1);
        chk("fp_m1_rdata", fp_m1_rdata, 32'hCAFE_0001);
        cyc();
        s_ready = 1'b0; m1_valid = 1'b0;
        cyc();

        // ---------------- Single read ----------------
        m0_valid = 1'b1; m0_addr = 32'h2000_0010; m0_wstrb = 4'd0;
        #1;
        chk("rd_arb_s_valid", rr_s_valid, 1'b0);
        cyc();
        chk("rd_s_valid", rr_s_valid, 1'b1);
        chk("rd_grant", rr_grant, 2'b01);
        chk("rd_busy", rr_busy, 1'b1);
        chk("rd_s_addr", rr_s_addr, 32'h2000_0010);
        chk("rd_wait_ready", rr_m0_ready, 1'b0);
        cyc();
        chk("rd_wait2_ready", rr_m0_ready, 1'b0);
        cyc();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        chk("rd_m0_ready", rr_m0_ready, 1'b1);
        chk("rd_m0_rdata", rr_m0_rdata, 32'h1234_5678);
        cyc();
        // DONE: late valid drop and spurious s_ready must be ignored
        #1;
        chk("rd_done_s_valid", rr_s_valid, 1'b0);
        chk("rd_done_ready", rr_m0_ready, 1'b0);
        chk("rd_done_grant", rr_grant, 2'b00);
        chk("rd_done_busy", rr_busy, 1'b0);
        m0_valid = 1'b0;
        cyc();
        s_ready = 1'b0;
        #1;
        chk("rd_idle_grant", rr_grant, 2'b00);

        // ---------------- Write passthrough (m1) ----------------
        m1_valid = 1'b1; m1_addr = 32'h4000_0000; m1_wdata = 32'h0000_00A5; m1_wstrb = 4'b0001;
        cyc();
        chk("wr_s_valid", rr_s_valid, 1'b1);
        chk("wr_grant", rr_grant, 2'b10);
        chk("wr_s_addr", rr_s_addr, 32'h4000_0000);
        chk("wr_s_wdata", rr_s_wdata, 32'h0000_00A5);
        chk("wr_s_wstrb", rr_s_wstrb, 4'b0001);
        s_ready = 1'b1; s_rdata = 32'h0;
        #1;
        chk("wr_m1_ready", rr_m1_ready, 1'b1);
        chk("wr_m0_ready", rr_m0_ready, 1'b0);
        cyc();
        s_ready = 1'b0; m1_valid = 1'b0;
        cyc();

        // ---------------- Aborts ----------------
        m1_valid = 1'b1;
        cyc();
        chk("ab1_grant", rr_grant, 2'b10);
        m1_valid = 1'b0;
        #1;
        chk("ab1_s_valid", rr_s_valid, 1'b0);
        chk("ab1_m1_ready", rr_m1_ready, 1'b0);
        chk("ab1_m1_err", rr_m1_err, 1'b0);
        cyc();
        chk("ab1_idle_grant", rr_grant, 2'b00);
        chk("ab1_idle_busy", rr_busy, 1'b0);
        // m0 abort while last=1: last must stay 1
        m0_valid = 1'b1;
        cyc();
        chk("ab0_grant", rr_grant, 2'b01);
        m0_valid = 1'b0;
        #1;
        chk("ab0_m0_ready", rr_m0_ready, 1'b0);
        cyc();
        chk("ab0_idle_grant", rr_grant, 2'b00);
        m0_valid = 1'b1; m1_valid = 1'b1;
        cyc();
        chk("ab_last_kept", rr_grant, 2'b01);
        s_ready = 1'b1;
        cyc();
        s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        cyc();

        // ---------------- Async reset mid-transfer ----------------
        m0_valid = 1'b1;
        cyc();
        chk("ar_s_valid_pre", rr_s_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("ar_s_valid", rr_s_valid, 1'b0);
        chk("ar_grant", rr_grant, 2'b00);
        m0_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        // ---------------- Stuck slave / timeout ----------------
        m0_valid = 1'b1; s_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("to_wait_s_valid", rr_s_valid, 1'b1);
            chk("to_wait_err", rr_m0_err, 1'b0);
            cyc();
        end
`ifdef ARB_TIMEOUT_EN
        chk("to_m0_ready", rr_m0_ready, 1'b1);
        chk("to_m0_err", rr_m0_err, 1'b1);
        chk("to_m0_rdata", rr_m0_rdata, 32'hDEAD_BEEF);
        chk("to_s_valid", rr_s_valid, 1'b0);
        cyc();
        chk("to_done_grant", rr_grant, 2'b00);
        chk("to_done_ready", rr_m0_ready, 1'b0);
        m0_valid = 1'b0;
        cyc();
        chk("to_idle_busy", rr_busy, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            chk("stuck_busy", rr_busy, 1'b1);
            chk("stuck_ready", rr_m0_ready, 1'b0);
            cyc();
        end
        m0_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
